// File: rtl/rv16_wb_arb.sv
// Writeback arbiter: grants one of ALU/LSU per cycle onto a registered write port and
// tracks pending destination registers. Define RV16_WB_RR_EN for round-robin arbitration.
module rv16_wb_arb #(
  parameter int unsigned DATA = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [3:0]      alu_rd,
  input  logic [DATA-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [3:0]      lsu_rd,
  input  logic [DATA-1:0] lsu_data,
  output logic            lsu_ready,
  input  logic            iss_valid,
  input  logic [3:0]      iss_rd,
  input  logic            wb_stall,
  output logic            wb_en,
  output logic [3:0]      wb_addr,
  output logic [DATA-1:0] wb_data,
  output logic [15:0]     busy
);

  logic            grant;
  logic            write;
  logic [3:0]      grant_rd;
  logic [DATA-1:0] grant_data;
  logic            wb_en_q;
  logic [3:0]      wb_addr_q;
  logic [DATA-1:0] wb_data_q;
  logic [15:0]     busy_q, busy_d;

`ifdef RV16_WB_RR_EN
  // ptr_q = 0 favours the ALU on contention, 1 favours the LSU.
  logic ptr_q, ptr_d;

  always_comb begin
    alu_ready = ~wb_stall & alu_valid & (~lsu_valid | ~ptr_q);
    lsu_ready = ~wb_stall & lsu_valid & (~alu_valid | ptr_q);
    ptr_d     = ptr_q;
    if (alu_ready && lsu_valid) begin
      ptr_d = 1'b1;
    end else if (lsu_ready && alu_valid) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    lsu_ready = ~wb_stall & lsu_valid;
    alu_ready = ~wb_stall & alu_valid & ~lsu_valid;
  end
`endif

  always_comb begin
    grant      = alu_ready | lsu_ready;
    grant_rd   = lsu_ready ? lsu_rd : alu_rd;
    grant_data = lsu_ready ? lsu_data : alu_data;
    // x0 grants are consumed without producing a write.
    write      = grant & (grant_rd != 4'd0);
  end

  // Issue-side set is applied after the grant-side clear so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (grant) begin
      busy_d[grant_rd] = 1'b0;
    end
    if (iss_valid) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      busy_q    <= '0;
    end else begin
      wb_en_q <= write;
      busy_q  <= busy_d;
      if (write) begin
        wb_addr_q <= grant_rd;
        wb_data_q <= grant_data;
      end
    end
  end

  assign wb_en   = wb_en_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;
  assign busy    = busy_q;

endmodule
